pipelined_addsub32: RTL and testbench
=====================================

Name: pipelined_addsub32

Overview:
- Two-stage pipelined 32-bit adder/subtractor with a valid/ready handshake on input and output.
- Stage 1 computes the low half and both speculative upper halves (carry-in 0 and 1).
- Stage 2 selects the correct upper half using the registered low-half carry, then produces carry-out and signed overflow.
- Serves as the streaming arithmetic unit behind the combinational carry-select adders, accepting one operation per cycle under backpressure.

Parameters:
- WIDTH, 32, operand/result width; must be even.
- HALF, WIDTH/2, derived split point; not overridden by users.

Ports:
- clk  input  1  clock; all state on rising edge
- resetn  input  1  reset, asynchronous, active-low
- in_valid  input  1  operation presented on a, b, sub
- in_ready  output  1  block accepts operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result/cout/overflow valid
- out_ready  input  1  consumer accepts result this cycle
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- cout  output  1  carry-out; for subtract, 1 = no borrow (A >= B unsigned)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Operation: bx = b XOR {WIDTH{sub}}; result = a + bx + sub, truncated to WIDTH bits.
- Stage 1 registers:
  - lo_sum, lo_carry = a[HALF-1:0] + bx[HALF-1:0] + sub
  - hi0 = a_hi + bx_hi + 0 (HALF+1 bits, incl. carry)
  - hi1 = a_hi + bx_hi + 1 (HALF+1 bits, incl. carry)
  - sign bits a[WIDTH-1], bx[WIDTH-1]
  - valid bit v1
- Stage 2 registers:
  - hi = lo_carry ? hi1 : hi0
  - result = {hi[HALF-1:0], lo_sum}; cout = hi[HALF]
  - overflow = (a_msb == bx_msb) && (result[WIDTH-1] != a_msb)
  - valid bit v2 drives out_valid
- Handshake:
  - Transfer occurs when valid && ready are both high on a rising edge.
  - out_valid holds, and result/cout/overflow stay stable, until out_ready is sampled high.
  - Stage 2 advances when !v2 || out_ready.
  - Stage 1 advances when !v1 || stage-2 advance.
  - in_ready = !v1 || stage-2 advance (combinational, no path from in_valid).
- Latency and throughput:
  - Latency is exactly 2 cycles from input acceptance to out_valid when out_ready stays high.
  - Sustained throughput is 1 operation per cycle.
- Simultaneous events: a transfer into stage 1 and out of stage 1 in the same cycle keeps v1 = 1 with the new data. The same rule applies to stage 2.
- Ordering: results leave strictly in acceptance order; no drop, no duplication. Maximum in flight: 2.
- Reset (resetn low, asynchronous):
  - v1 = v2 = 0, hence out_valid = 0 immediately.
  - result = 0, cout = 0, overflow = 0; all stage-1 data registers = 0.
  - in_ready = 1 from the first cycle after release.
  - In-flight operations are discarded when reset is asserted mid-operation.
- Idle: with out_valid = 0, the result/cout/overflow outputs hold their last values (0 after reset). Consumers ignore them.
- Boundary: wrap-around is modulo 2^WIDTH. The carry between halves propagates across both the HALF-1 and HALF boundaries via hi1 selection (e.g. 0x0000FFFF+1).

Test Plan:
- Add 0x0000FFFF + 0x00000001, sub=0, out_ready=1 -> 2 cycles later result=0x00010000, cout=0, overflow=0 (lo_carry selects hi1).
- Sub 0x00000005 - 0x00000007 -> result=0xFFFFFFFE, cout=0 (borrow), overflow=0. Sub 7-5 -> 0x00000002, cout=1.
- Add 0x7FFFFFFF+1 -> 0x80000000, overflow=1, cout=0. Add 0xFFFFFFFF+1 -> 0x00000000, cout=1, overflow=0. Sub 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
- Stream 5 back-to-back ops with out_ready=1 -> 5 consecutive out_valid cycles, in order, starting cycle 2.
- Stream ops (1+1, 2+2, 3+3) with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted, out_valid=1 holding 2 stable. On release: 2, 4, 6 in order, no loss or duplicate.
- Assert resetn=0 with v1=v2=1 between clock edges -> out_valid=0 and result=0 immediately. After release, in_ready=1 and no stale result is emitted.

Source files
------------

// File: rtl/pipelined_addsub32.sv
// pipelined_addsub32
//   Two-stage pipelined adder/subtractor with valid/ready handshakes.
//   Stage 1 computes the low-half sum and both possible upper-half sums
//   (carry-in 0 and carry-in 1). Stage 2 picks the correct upper half with
//   the registered low-half carry, then forms carry-out and signed overflow.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   resetn    - asynchronous active-low reset
//   in_valid  - an operation is presented on a, b, sub
//   in_ready  - the block accepts the presented operation this cycle
//   a, b      - operands (WIDTH bits)
//   sub       - 0 = a + b, 1 = a - b
//   out_valid - result/cout/overflow hold a valid result
//   out_ready - consumer accepts the result this cycle
//   result    - sum or difference, modulo 2^WIDTH
//   cout      - carry-out; for subtract, 1 means no borrow (a >= b unsigned)
//   overflow  - signed two's-complement overflow

module pipelined_addsub32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int HALF = WIDTH / 2;

  // Stage 1 registers
  logic            v1_q, v1_d;
  logic [HALF-1:0] lo_sum_q, lo_sum_d;
  logic            lo_carry_q, lo_carry_d;
  logic [HALF:0]   hi0_q, hi0_d;
  logic [HALF:0]   hi1_q, hi1_d;
  logic            a_msb_q, a_msb_d;
  logic            bx_msb_q, bx_msb_d;

  // Stage 2 registers
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  // Combinational intermediates
  logic [WIDTH-1:0] bx;
  logic [HALF:0]    lo_calc;
  logic [HALF:0]    hi0_calc;
  logic [HALF:0]    hi1_calc;
  logic [HALF:0]    hi_sel;
  logic [WIDTH-1:0] result_calc;
  logic             adv1, adv2;
  logic             load1, load2;

  // A stage may take new data when it is empty or its content moves on
  // this cycle; in_ready therefore depends on out_ready but never on in_valid.
  always_comb begin
    adv2  = !v2_q || out_ready;
    adv1  = !v1_q || adv2;
    load1 = in_valid && adv1;
    load2 = v1_q && adv2;
  end

  assign in_ready = adv1;

  // Stage 1 arithmetic: subtraction is a + ~b + 1, with the +1 folded into
  // the low-half carry-in. Both upper-half outcomes are precomputed so that
  // stage 2 only has to select one.
  always_comb begin
    bx       = b ^ {WIDTH{sub}};
    lo_calc  = {1'b0, a[HALF-1:0]} + {1'b0, bx[HALF-1:0]} + {{HALF{1'b0}}, sub};
    hi0_calc = {1'b0, a[WIDTH-1:HALF]} + {1'b0, bx[WIDTH-1:HALF]};
    hi1_calc = hi0_calc + {{HALF{1'b0}}, 1'b1};
  end

  // Stage 2 arithmetic: carry select and signed overflow from the operand
  // sign bits captured in stage 1.
  always_comb begin
    hi_sel      = lo_carry_q ? hi1_q : hi0_q;
    result_calc = {hi_sel[HALF-1:0], lo_sum_q};
  end

  // Next-state logic. Data registers only load on an actual transfer so the
  // outputs keep their last value while the pipeline is idle.
  always_comb begin
    v1_d       = v1_q;
    lo_sum_d   = lo_sum_q;
    lo_carry_d = lo_carry_q;
    hi0_d      = hi0_q;
    hi1_d      = hi1_q;
    a_msb_d    = a_msb_q;
    bx_msb_d   = bx_msb_q;
    v2_d       = v2_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    if (adv1) begin
      v1_d = in_valid;
    end
    if (load1) begin
      lo_sum_d   = lo_calc[HALF-1:0];
      lo_carry_d = lo_calc[HALF];
      hi0_d      = hi0_calc;
      hi1_d      = hi1_calc;
      a_msb_d    = a[WIDTH-1];
      bx_msb_d   = bx[WIDTH-1];
    end

    if (adv2) begin
      v2_d = v1_q;
    end
    if (load2) begin
      result_d   = result_calc;
      cout_d     = hi_sel[HALF];
      overflow_d = (a_msb_q == bx_msb_q) && (result_calc[WIDTH-1] != a_msb_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1_q       <= 1'b0;
      lo_sum_q   <= '0;
      lo_carry_q <= 1'b0;
      hi0_q      <= '0;
      hi1_q      <= '0;
      a_msb_q    <= 1'b0;
      bx_msb_q   <= 1'b0;
      v2_q       <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      lo_sum_q   <= lo_sum_d;
      lo_carry_q <= lo_carry_d;
      hi0_q      <= hi0_d;
      hi1_q      <= hi1_d;
      a_msb_q    <= a_msb_d;
      bx_msb_q   <= bx_msb_d;
      v2_q       <= v2_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = v2_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_addsub32.sv
// tb_pipelined_addsub32
//   Self-checking bench for pipelined_addsub32. Expected results come from a
//   plain-arithmetic reference model (wide unsigned sum for result/carry,
//   signed 64-bit arithmetic for overflow) and a queue of accepted operations.
//   Inputs are driven just after the falling edge and outputs are sampled
//   1 time unit later, well away from the rising edge.

module tb_pipelined_addsub32;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        overflow;

  int n_vec;
  int n_err;

  // Expected {cout, overflow, result} of accepted but not yet delivered ops
  logic [33:0] exp_q[$];

  pipelined_addsub32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {cout, overflow, result}
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic msub);
    logic [32:0] u;
    longint      sa, sb, sr;
    logic        ovf;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      u  = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
      sr = sa - sb;
    end else begin
      u  = {1'b0, ma} + {1'b0, mb};
      sr = sa + sb;
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {u[32], ovf, u[31:0]};
  endfunction

  // Operand generator biased towards the interesting corner values
  function automatic logic [31:0] pick();
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h0000_FFFF;
    corners[5] = 32'h0000_0001;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // One clock cycle: drive after the falling edge, leave 1 unit for settling
  task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic is, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    sub       = is;
    out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_vec++;
    if ({out_valid, cout, overflow, result} !== 35'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got v=%b c=%b o=%b r=%h expected all 0",
               out_valid, cout, overflow, result);
    end
  endtask

  // Single isolated operations: exact 2-cycle latency and value checks
  task automatic test_directed();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic        vs [7];
    logic [33:0] e;
    logic [31:0] ta, tb;
    logic        ts;
    va[0] = 32'h0000_FFFF; vb[0] = 32'h0000_0001; vs[0] = 1'b0;
    va[1] = 32'h0000_0005; vb[1] = 32'h0000_0007; vs[1] = 1'b1;
    va[2] = 32'h0000_0007; vb[2] = 32'h0000_0005; vs[2] = 1'b1;
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'h0000_0001; vs[3] = 1'b0;
    va[4] = 32'hFFFF_FFFF; vb[4] = 32'h0000_0001; vs[4] = 1'b0;
    va[5] = 32'h8000_0000; vb[5] = 32'h0000_0001; vs[5] = 1'b1;
    va[6] = 32'h0000_0000; vb[6] = 32'h8000_0000; vs[6] = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i < 7) begin
        ta = va[i]; tb = vb[i]; ts = vs[i];
      end else begin
        ta = pick(); tb = pick(); ts = 1'($urandom_range(0, 1));
      end
      e = model(ta, tb, ts);
      drive(1'b1, ta, tb, ts, 1'b1);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL directed_early[%0d]: out_valid got %b expected 0", i, out_valid);
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || {cout, overflow, result} !== e) begin
        n_err++;
        $display("[TB] FAIL directed[%0d] %h %s %h: got v=%b c=%b o=%b r=%h expected v=1 c=%b o=%b r=%h",
                 i, ta, ts ? "-" : "+", tb, out_valid, cout, overflow, result,
                 e[33], e[32], e[31:0]);
      end
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  // Five consecutive ops with no backpressure: outputs on cycles 2..6
  task automatic test_back_to_back();
    logic [31:0] ta, tb;
    logic        ts;
    logic [33:0] e;
    exp_q.delete();
    for (int c = 0; c < 8; c++) begin
      ta = pick(); tb = pick(); ts = 1'($urandom_range(0, 1));
      drive(c < 5, ta, tb, ts, 1'b1);
      n_vec++;
      if (out_valid !== (c >= 2 && c <= 6)) begin
        n_err++;
        $display("[TB] FAIL b2b_valid[cycle %0d]: got %b expected %b", c, out_valid,
                 (c >= 2 && c <= 6));
      end
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({cout, overflow, result} !== e) begin
          n_err++;
          $display("[TB] FAIL b2b_data[cycle %0d]: got %h expected %h", c,
                   {cout, overflow, result}, e);
        end
      end
      if (c < 5) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL b2b_in_ready[cycle %0d]: got %b expected 1", c, in_ready);
        end
        if (in_ready) exp_q.push_back(model(ta, tb, ts));
      end
    end
  endtask

  // 1+1, 2+2, 3+3 with the consumer stalled for the first four cycles
  task automatic test_backpressure();
    logic [31:0] want [3];
    int          k, n_out;
    logic        prev_stall;
    logic [33:0] prev_obs;
    logic        ordy;
    want[0] = 32'd2; want[1] = 32'd4; want[2] = 32'd6;
    k = 0;
    n_out = 0;
    prev_stall = 1'b0;
    prev_obs = '0;
    for (int c = 0; c < 12; c++) begin
      ordy = (c >= 4);
      drive(k < 3, 32'(k + 1), 32'(k + 1), 1'b0, ordy);
      if (c == 2 || c == 3) begin
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd2) begin
          n_err++;
          $display("[TB] FAIL bp_stall[cycle %0d]: got rdy=%b v=%b r=%h expected rdy=0 v=1 r=00000002",
                   c, in_ready, out_valid, result);
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || {cout, overflow, result} !== prev_obs) begin
          n_err++;
          $display("[TB] FAIL bp_hold[cycle %0d]: got v=%b %h expected v=1 %h",
                   c, out_valid, {cout, overflow, result}, prev_obs);
        end
      end
      if (out_valid && ordy) begin
        n_vec++;
        if (n_out >= 3 || result !== want[n_out]) begin
          n_err++;
          $display("[TB] FAIL bp_order[%0d]: got %h expected %h", n_out, result,
                   (n_out < 3) ? want[n_out] : 32'hxxxx_xxxx);
        end
        n_out++;
      end
      prev_stall = out_valid && !ordy;
      prev_obs   = {cout, overflow, result};
      if (k < 3 && in_ready) k++;
    end
    n_vec++;
    if (n_out != 3) begin
      n_err++;
      $display("[TB] FAIL bp_count: got %0d results expected 3", n_out);
    end
  endtask

  // Long randomized run with random valid/ready against the queue model
  task automatic test_random_stream();
    logic [31:0] ta, tb;
    logic        ts, iv, ordy;
    logic [33:0] e;
    logic        prev_stall;
    logic [33:0] prev_obs;
    int          in_flight;
    int          drain;
    exp_q.delete();
    prev_stall = 1'b0;
    prev_obs = '0;
    in_flight = 0;
    for (int c = 0; c < 400; c++) begin
      ta = pick(); tb = pick(); ts = 1'($urandom_range(0, 1));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive(iv, ta, tb, ts, ordy);
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || {cout, overflow, result} !== prev_obs) begin
          n_err++;
          $display("[TB] FAIL rand_hold[cycle %0d]: got v=%b %h expected v=1 %h",
                   c, out_valid, {cout, overflow, result}, prev_obs);
        end
      end
      if (out_valid && ordy) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL rand_extra[cycle %0d]: got %h expected no result",
                   c, {cout, overflow, result});
        end else begin
          e = exp_q.pop_front();
          if ({cout, overflow, result} !== e) begin
            n_err++;
            $display("[TB] FAIL rand_data[cycle %0d]: got %h expected %h", c,
                     {cout, overflow, result}, e);
          end
          in_flight--;
        end
      end
      if (iv && in_ready) begin
        exp_q.push_back(model(ta, tb, ts));
        in_flight++;
      end
      if (in_flight > 2) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL rand_in_flight[cycle %0d]: got %0d expected at most 2", c, in_flight);
        in_flight = 2;
      end
      prev_stall = out_valid && !ordy;
      prev_obs   = {cout, overflow, result};
    end
    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      if (out_valid) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({cout, overflow, result} !== e) begin
          n_err++;
          $display("[TB] FAIL rand_drain: got %h expected %h", {cout, overflow, result}, e);
        end
      end
      drain++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL rand_lost: got %0d undelivered expected 0", exp_q.size());
    end
  endtask

  // Reset asserted between clock edges with both stages full
  task automatic test_reset_midflight();
    drive(1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
    drive(1'b1, 32'd30, 32'd40, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midreset_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
    end
    #1;
    resetn = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || result !== 32'd0 || cout !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midreset_async: got v=%b r=%h c=%b o=%b expected all 0",
               out_valid, result, cout, overflow);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL midreset_stale[cycle %0d]: got v=%b rdy=%b expected v=0 rdy=1",
                 c, out_valid, in_ready);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    test_random_stream();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
